mm2s_cmd_engine: RTL and testbench

Memory-to-stream transfer engine that executes the 72-bit command words issued by the team's command/status register block. It accepts one command over a valid/ready handshake, fetches the requested bytes from memory with AXI4 INCR read bursts, and forwards them unchanged on an AXI-Stream master. When the transfer finishes it returns an 8-bit status beat whose bit 7 (OKAY) is what the register block latches into its status register.

---
 rtl/mm2s_cmd_engine.sv | 274 +++++++++++++++++++++++++++
 tb/tb_mm2s_cmd_engine.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mm2s_cmd_engine.sv
`default_nettype none
// ============================================================================
//  Module   : mm2s_cmd_engine
//  Purpose  : Executes one 72-bit command at a time. Fetches BTT bytes from
//             memory at SADDR using AXI4 INCR read bursts (never crossing a
//             4 KB page) and forwards the read data unchanged on an
//             AXI-Stream master. Returns an 8-bit status beat on completion.
//  Ports    : S_AXI_ACLK / S_AXI_ARESETN   clock, synchronous active-low reset
//             pi_command/pi_valid/po_ready  command handshake
//                 [22:0] BTT, [30] EOF, [63:32] SADDR, [67:64] TAG
//             po_sts_*/pi_sts_tready        status beat
//                 [3:0] TAG, [4] INTERR, [5] DECERR, [6] SLVERR, [7] OKAY
//             M_AXI_AR*                     read address channel
//             M_AXI_R*                      read data channel
//             M_AXIS_*                      stream master (RDATA pass-through)
//  Revision : 1.0  initial release
// ============================================================================
module mm2s_cmd_engine #(
    parameter int C_M_AXI_DATA_WIDTH = 32,
    parameter int C_M_AXI_ADDR_WIDTH = 32,
    parameter int C_MAX_BURST_LEN    = 16
) (
    input  logic                              S_AXI_ACLK,
    input  logic                              S_AXI_ARESETN,
    // command / status
    input  logic [71:0]                       pi_command,
    input  logic                              pi_valid,
    output logic                              po_ready,
    output logic [7:0]                        po_sts_tdata,
    output logic                              po_sts_tvalid,
    input  logic                              pi_sts_tready,
    // AXI4 read address
    output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_ARADDR,
    output logic [7:0]                        M_AXI_ARLEN,
    output logic [2:0]                        M_AXI_ARSIZE,
    output logic [1:0]                        M_AXI_ARBURST,
    output logic                              M_AXI_ARVALID,
    input  logic                              M_AXI_ARREADY,
    // AXI4 read data
    input  logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_RDATA,
    input  logic [1:0]                        M_AXI_RRESP,
    input  logic                              M_AXI_RLAST,
    input  logic                              M_AXI_RVALID,
    output logic                              M_AXI_RREADY,
    // AXI-Stream master
    output logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXIS_TDATA,
    output logic [C_M_AXI_DATA_WIDTH/8-1:0]   M_AXIS_TKEEP,
    output logic                              M_AXIS_TLAST,
    output logic                              M_AXIS_TVALID,
    input  logic                              M_AXIS_TREADY
);

    localparam int               c_KW        = C_M_AXI_DATA_WIDTH / 8;
    localparam int               c_AW        = C_M_AXI_ADDR_WIDTH;
    localparam logic [21:0]      c_MAX_BEATS = 22'(C_MAX_BURST_LEN);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_ADDR = 2'd1;
    localparam logic [1:0] c_ST_DATA = 2'd2;
    localparam logic [1:0] c_ST_STS  = 2'd3;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    logic [1:0]      r_state;
    logic [1:0]      w_state_nxt;
    logic            r_out_en;      // low during reset and the release edge
    logic [c_AW-1:0] r_addr;        // start address of current burst
    logic [21:0]     r_words_rem;   // words left, including current burst
    logic [8:0]      r_beats;       // beats in current burst
    logic [8:0]      r_beat_cnt;    // beats already accepted in current burst
    logic [7:0]      r_arlen;
    logic [1:0]      r_btt_lo;
    logic            r_eof;
    logic [3:0]      r_tag;
    logic            r_interr;
    logic            r_slverr;
    logic            r_decerr;

    // ------------------------------------------------------------------
    // Command decode
    // ------------------------------------------------------------------
    logic [22:0]     w_cmd_btt;
    logic [c_AW-1:0] w_cmd_addr;
    logic [21:0]     w_cmd_words;
    logic            w_accept;
    logic            w_reject;
    logic            w_unused;

    assign w_cmd_btt   = pi_command[22:0];
    assign w_cmd_addr  = pi_command[32 +: c_AW];
    assign w_cmd_words = 22'((24'(w_cmd_btt) + 24'd3) >> 2);
    assign w_accept    = po_ready && pi_valid;
    assign w_reject    = (w_cmd_btt == 23'd0) || (w_cmd_addr[1:0] != 2'b00);
    assign w_unused    = &{1'b0, pi_command[71:68], pi_command[31], pi_command[29:23]};

    // ------------------------------------------------------------------
    // Next-burst planning. In IDLE the first burst is planned from the
    // command word; otherwise from the burst that is finishing. Burst size
    // is the smallest of the configured maximum, the remaining words and
    // the words left before the next 4 KB page.
    // ------------------------------------------------------------------
    logic [c_AW-1:0] w_nxt_addr;
    logic [21:0]     w_nxt_words;
    logic [21:0]     w_to_bound;
    logic [21:0]     w_min;
    logic [8:0]      w_nxt_beats;

    always_comb begin
        if (r_state == c_ST_IDLE) begin
            w_nxt_addr  = w_cmd_addr;
            w_nxt_words = w_cmd_words;
        end else begin
            w_nxt_addr  = r_addr + (c_AW'(r_beats) << 2);
            w_nxt_words = r_words_rem - 22'(r_beats);
        end
        w_to_bound = 22'd1024 - 22'(w_nxt_addr[11:2]);
        w_min      = w_nxt_words;
        if (w_min > c_MAX_BEATS) begin
            w_min = c_MAX_BEATS;
        end
        if (w_min > w_to_bound) begin
            w_min = w_to_bound;
        end
        w_nxt_beats = 9'(w_min);
    end

    // ------------------------------------------------------------------
    // Beat tracking
    // ------------------------------------------------------------------
    logic w_r_hs;
    logic w_last_in_burst;
    logic w_burst_done;
    logic w_more;
    logic w_final_beat;

    assign w_r_hs          = (r_state == c_ST_DATA) && M_AXI_RVALID && M_AXIS_TREADY;
    assign w_last_in_burst = (r_beat_cnt == (r_beats - 9'd1));
    assign w_burst_done    = w_r_hs && w_last_in_burst;
    assign w_more          = (w_nxt_words != 22'd0);
    assign w_final_beat    = w_last_in_burst && (r_words_rem == 22'(r_beats));

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge S_AXI_ACLK) begin
        if (!S_AXI_ARESETN) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = w_reject ? c_ST_STS : c_ST_ADDR;
                end
            end
            c_ST_ADDR: begin
                if (M_AXI_ARREADY) begin
                    w_state_nxt = c_ST_DATA;
                end
            end
            c_ST_DATA: begin
                if (w_burst_done) begin
                    w_state_nxt = w_more ? c_ST_ADDR : c_ST_STS;
                end
            end
            default: begin
                if (pi_sts_tready) begin
                    w_state_nxt = c_ST_IDLE;
                end
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        po_ready      = (r_state == c_ST_IDLE) && r_out_en;
        po_sts_tvalid = (r_state == c_ST_STS);
        po_sts_tdata  = 8'h00;
        if (r_state == c_ST_STS) begin
            po_sts_tdata = {~(r_slverr | r_decerr | r_interr),
                            r_slverr, r_decerr, r_interr, r_tag};
        end

        M_AXI_ARADDR  = r_addr;
        M_AXI_ARLEN   = r_arlen;
        M_AXI_ARSIZE  = 3'b010;
        M_AXI_ARBURST = 2'b01;
        M_AXI_ARVALID = (r_state == c_ST_ADDR);

        M_AXI_RREADY  = (r_state == c_ST_DATA) && M_AXIS_TREADY;
        M_AXIS_TVALID = (r_state == c_ST_DATA) && M_AXI_RVALID;
        M_AXIS_TDATA  = M_AXI_RDATA;
        M_AXIS_TLAST  = (r_state == c_ST_DATA) && w_final_beat && r_eof;
        M_AXIS_TKEEP  = {c_KW{1'b1}};
        if (w_final_beat) begin
            case (r_btt_lo)
                2'd1:    M_AXIS_TKEEP = c_KW'(4'h1);
                2'd2:    M_AXIS_TKEEP = c_KW'(4'h3);
                2'd3:    M_AXIS_TKEEP = c_KW'(4'h7);
                default: M_AXIS_TKEEP = {c_KW{1'b1}};
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge S_AXI_ACLK) begin
        if (!S_AXI_ARESETN) begin
            r_out_en    <= 1'b0;
            r_addr      <= '0;
            r_words_rem <= 22'd0;
            r_beats     <= 9'd0;
            r_beat_cnt  <= 9'd0;
            r_arlen     <= 8'd0;
            r_btt_lo    <= 2'd0;
            r_eof       <= 1'b0;
            r_tag       <= 4'd0;
            r_interr    <= 1'b0;
            r_slverr    <= 1'b0;
            r_decerr    <= 1'b0;
        end else begin
            r_out_en <= 1'b1;

            if (w_accept) begin
                r_btt_lo <= w_cmd_btt[1:0];
                r_eof    <= pi_command[30];
                r_tag    <= pi_command[67:64];
                r_interr <= w_reject;
                r_slverr <= 1'b0;
                r_decerr <= 1'b0;
            end

            // Load a new burst plan at command start or when a burst ends
            // with words still outstanding.
            if ((w_accept && !w_reject) || (w_burst_done && w_more)) begin
                r_addr      <= w_nxt_addr;
                r_words_rem <= w_nxt_words;
                r_beats     <= w_nxt_beats;
                r_arlen     <= 8'(w_nxt_beats - 9'd1);
                r_beat_cnt  <= 9'd0;
            end else if (w_r_hs) begin
                r_beat_cnt  <= r_beat_cnt + 9'd1;
            end

            if (w_r_hs) begin
                if (M_AXI_RRESP == 2'b10) begin
                    r_slverr <= 1'b1;
                end
                if (M_AXI_RRESP == 2'b11) begin
                    r_decerr <= 1'b1;
                end
                // The local count is authoritative; a disagreeing RLAST
                // is only flagged.
                if (M_AXI_RLAST != w_last_in_burst) begin
                    r_interr <= 1'b1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mm2s_cmd_engine.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mm2s_cmd_engine
//  Purpose  : Self-checking bench for mm2s_cmd_engine. A memory slave serves
//             a fixed address-to-data image; expected bursts, stream beats
//             and status are computed from the transfer rules per command.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mm2s_cmd_engine;

    localparam int MAX_BURST = 16;

    logic        S_AXI_ACLK = 1'b0;
    logic        S_AXI_ARESETN;
    logic [71:0] pi_command;
    logic        pi_valid;
    logic        po_ready;
    logic [7:0]  po_sts_tdata;
    logic        po_sts_tvalid;
    logic        pi_sts_tready;
    logic [31:0] M_AXI_ARADDR;
    logic [7:0]  M_AXI_ARLEN;
    logic [2:0]  M_AXI_ARSIZE;
    logic [1:0]  M_AXI_ARBURST;
    logic        M_AXI_ARVALID;
    logic        M_AXI_ARREADY;
    logic [31:0] M_AXI_RDATA;
    logic [1:0]  M_AXI_RRESP;
    logic        M_AXI_RLAST;
    logic        M_AXI_RVALID;
    logic        M_AXI_RREADY;
    logic [31:0] M_AXIS_TDATA;
    logic [3:0]  M_AXIS_TKEEP;
    logic        M_AXIS_TLAST;
    logic        M_AXIS_TVALID;
    logic        M_AXIS_TREADY;

    int n_checks = 0;
    int n_errors = 0;

    mm2s_cmd_engine #(
        .C_M_AXI_DATA_WIDTH (32),
        .C_M_AXI_ADDR_WIDTH (32),
        .C_MAX_BURST_LEN    (MAX_BURST)
    ) u_dut (
        .S_AXI_ACLK    (S_AXI_ACLK),
        .S_AXI_ARESETN (S_AXI_ARESETN),
        .pi_command    (pi_command),
        .pi_valid      (pi_valid),
        .po_ready      (po_ready),
        .po_sts_tdata  (po_sts_tdata),
        .po_sts_tvalid (po_sts_tvalid),
        .pi_sts_tready (pi_sts_tready),
        .M_AXI_ARADDR  (M_AXI_ARADDR),
        .M_AXI_ARLEN   (M_AXI_ARLEN),
        .M_AXI_ARSIZE  (M_AXI_ARSIZE),
        .M_AXI_ARBURST (M_AXI_ARBURST),
        .M_AXI_ARVALID (M_AXI_ARVALID),
        .M_AXI_ARREADY (M_AXI_ARREADY),
        .M_AXI_RDATA   (M_AXI_RDATA),
        .M_AXI_RRESP   (M_AXI_RRESP),
        .M_AXI_RLAST   (M_AXI_RLAST),
        .M_AXI_RVALID  (M_AXI_RVALID),
        .M_AXI_RREADY  (M_AXI_RREADY),
        .M_AXIS_TDATA  (M_AXIS_TDATA),
        .M_AXIS_TKEEP  (M_AXIS_TKEEP),
        .M_AXIS_TLAST  (M_AXIS_TLAST),
        .M_AXIS_TVALID (M_AXIS_TVALID),
        .M_AXIS_TREADY (M_AXIS_TREADY)
    );

    always #5 S_AXI_ACLK = ~S_AXI_ACLK;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Memory image: a bijective address hash so every word is distinct.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    // Command word with random junk in the ignored bits.
    function automatic logic [71:0] make_cmd(input int btt, input logic [31:0] sa,
                                             input logic [3:0] tag, input bit eof);
        logic [71:0] c;
        c        = {8'($urandom), $urandom, $urandom};
        c[22:0]  = 23'(btt);
        c[30]    = eof;
        c[63:32] = sa;
        c[67:64] = tag;
        return c;
    endfunction

    task automatic run_cmd(input int btt, input logic [31:0] saddr, input logic [3:0] tag,
                           input bit eof, input bit stall, input int err_beat,
                           input logic [1:0] err_resp, input bit bad_rlast, input int sts_hold);
        logic [31:0] q_ar_addr[$];
        logic [7:0]  q_ar_len[$];
        logic [31:0] q_data[$];
        logic [3:0]  q_keep[$];
        logic        q_last[$];
        bit          reject;
        bit          done;
        int          words, rem, bnd, b, n, cyc;
        int          ar_wait, s_left, s_beat, sts_cnt;
        logic [31:0] a, s_addr;
        logic [7:0]  exp_sts, sts_first;

        // ---------------- reference model ----------------
        reject = (btt == 0) || (saddr[1:0] != 2'b00);
        words  = (btt + 3) / 4;
        if (!reject) begin
            a   = saddr;
            rem = words;
            while (rem > 0) begin
                bnd = (4096 - int'(a[11:0])) / 4;
                b   = rem;
                if (b > MAX_BURST) b = MAX_BURST;
                if (b > bnd) b = bnd;
                q_ar_addr.push_back(a);
                q_ar_len.push_back(8'(b - 1));
                a   = a + 32'(4 * b);
                rem = rem - b;
            end
            for (int i = 0; i < words; i++) begin
                q_data.push_back(mem_word(saddr + 32'(4 * i)));
                q_keep.push_back((i == words - 1 && btt % 4 != 0) ? 4'((1 << (btt % 4)) - 1) : 4'hF);
                q_last.push_back(eof && (i == words - 1));
            end
        end
        exp_sts[3:0] = tag;
        exp_sts[4]   = reject || bad_rlast;
        exp_sts[5]   = !reject && err_resp == 2'b11 && err_beat >= 1 && err_beat <= words;
        exp_sts[6]   = !reject && err_resp == 2'b10 && err_beat >= 1 && err_beat <= words;
        exp_sts[7]   = (exp_sts[6:4] == 3'b000);

        // ---------------- issue ----------------
        n = 0;
        while (!po_ready && n < 20) begin
            @(negedge S_AXI_ACLK);
            n++;
        end
        check_eq("cmd_ready", po_ready, 1'b1);
        pi_command = make_cmd(btt, saddr, tag, eof);
        pi_valid   = 1'b1;
        @(negedge S_AXI_ACLK);

        // ---------------- run ----------------
        ar_wait = -1; s_left = 0; s_beat = 0; sts_cnt = 0; s_addr = '0;
        done = 1'b0; cyc = 0; sts_first = '0;
        while (!done && cyc < 3000) begin
            pi_valid      = 1'($urandom_range(0, 1));
            pi_command    = {8'($urandom), $urandom, $urandom};
            M_AXIS_TREADY = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            M_AXI_ARREADY = 1'b0;
            if (M_AXI_ARVALID) begin
                if (ar_wait < 0) ar_wait = stall ? int'($urandom_range(0, 5)) : 0;
                if (ar_wait == 0) M_AXI_ARREADY = 1'b1;
                else ar_wait--;
            end
            if (s_left > 0) begin
                M_AXI_RVALID = stall ? ($urandom_range(0, 3) != 0) : 1'b1;
                M_AXI_RDATA  = mem_word(s_addr);
                M_AXI_RLAST  = bad_rlast ? 1'b0 : (s_left == 1);
                M_AXI_RRESP  = (s_beat + 1 == err_beat) ? err_resp : 2'b00;
            end else begin
                M_AXI_RVALID = 1'b0;
                M_AXI_RDATA  = '0;
                M_AXI_RLAST  = 1'b0;
                M_AXI_RRESP  = 2'b00;
            end
            pi_sts_tready = po_sts_tvalid && (sts_cnt >= sts_hold);
            #1;

            if (cyc == 0) begin
                check_eq("ready_drop", po_ready, 1'b0);
                check_eq("arvalid_start", M_AXI_ARVALID, !reject);
                check_eq("sts_start", po_sts_tvalid, reject);
            end

            if (s_left > 0) begin
                check_eq("rready_mirror", M_AXI_RREADY, M_AXIS_TREADY);
                check_eq("tvalid_mirror", M_AXIS_TVALID, M_AXI_RVALID);
            end
            if (M_AXIS_TVALID && M_AXIS_TREADY) begin
                check_eq("beat_avail", q_data.size() != 0, 1'b1);
                if (q_data.size() != 0) begin
                    check_eq("tdata", M_AXIS_TDATA, q_data.pop_front());
                    check_eq("tkeep", M_AXIS_TKEEP, q_keep.pop_front());
                    check_eq("tlast", M_AXIS_TLAST, q_last.pop_front());
                end
            end
            if (M_AXI_RVALID && M_AXI_RREADY && s_left > 0) begin
                s_left--;
                s_beat++;
                s_addr = s_addr + 32'd4;
            end

            if (M_AXI_ARVALID && M_AXI_ARREADY) begin
                check_eq("ar_single", s_left, 0);
                check_eq("ar_avail", q_ar_addr.size() != 0, 1'b1);
                check_eq("arsize", M_AXI_ARSIZE, 3'b010);
                check_eq("arburst", M_AXI_ARBURST, 2'b01);
                if (q_ar_addr.size() != 0) begin
                    check_eq("araddr", M_AXI_ARADDR, q_ar_addr.pop_front());
                    check_eq("arlen", M_AXI_ARLEN, q_ar_len.pop_front());
                end
                s_left  = int'(M_AXI_ARLEN) + 1;
                s_addr  = M_AXI_ARADDR;
                ar_wait = -1;
            end

            if (po_sts_tvalid) begin
                if (sts_cnt == 0) begin
                    sts_first = po_sts_tdata;
                end else begin
                    check_eq("sts_stable", po_sts_tdata, sts_first);
                    check_eq("ready_in_sts", po_ready, 1'b0);
                end
                if (pi_sts_tready) begin
                    check_eq("sts_data", po_sts_tdata, exp_sts);
                    done = 1'b1;
                end
                sts_cnt++;
            end

            if (!done) begin
                @(negedge S_AXI_ACLK);
                cyc++;
            end
        end
        check_eq("cmd_done", done, 1'b1);

        @(negedge S_AXI_ACLK);
        pi_valid      = 1'b0;
        pi_sts_tready = 1'b0;
        M_AXI_RVALID  = 1'b0;
        M_AXI_RLAST   = 1'b0;
        M_AXI_ARREADY = 1'b0;
        M_AXIS_TREADY = 1'b0;
        #1;
        check_eq("ready_back", po_ready, 1'b1);
        check_eq("sts_clear", po_sts_tvalid, 1'b0);
        check_eq("beats_left", q_data.size(), 0);
        check_eq("bursts_left", q_ar_addr.size(), 0);
    endtask

    task automatic check_reset_outputs(input string pfx);
        check_eq({pfx, "_ready"}, po_ready, 1'b0);
        check_eq({pfx, "_sts_tvalid"}, po_sts_tvalid, 1'b0);
        check_eq({pfx, "_sts_tdata"}, po_sts_tdata, 8'h00);
        check_eq({pfx, "_arvalid"}, M_AXI_ARVALID, 1'b0);
        check_eq({pfx, "_rready"}, M_AXI_RREADY, 1'b0);
        check_eq({pfx, "_tvalid"}, M_AXIS_TVALID, 1'b0);
        check_eq({pfx, "_tlast"}, M_AXIS_TLAST, 1'b0);
        check_eq({pfx, "_araddr"}, M_AXI_ARADDR, 32'h0);
        check_eq({pfx, "_arlen"}, M_AXI_ARLEN, 8'h0);
    endtask

    initial begin
        S_AXI_ARESETN = 1'b0;
        pi_command    = '0;
        pi_valid      = 1'b0;
        pi_sts_tready = 1'b1;
        M_AXI_ARREADY = 1'b1;
        M_AXI_RDATA   = '0;
        M_AXI_RRESP   = 2'b00;
        M_AXI_RLAST   = 1'b0;
        M_AXI_RVALID  = 1'b1;
        M_AXIS_TREADY = 1'b1;

        // Reset state, with valid/ready inputs high to expose leaks.
        repeat (3) @(negedge S_AXI_ACLK);
        #1;
        check_reset_outputs("rst");
        @(negedge S_AXI_ACLK);
        pi_sts_tready = 1'b0;
        M_AXI_ARREADY = 1'b0;
        M_AXI_RVALID  = 1'b0;
        M_AXIS_TREADY = 1'b0;
        S_AXI_ARESETN = 1'b1;
        #1;
        check_eq("ready_at_release", po_ready, 1'b0);
        @(negedge S_AXI_ACLK);
        #1;
        check_eq("ready_after_release", po_ready, 1'b1);

        // Directed cases
        run_cmd(64,  32'h0000_1000, 4'h5, 1'b1, 1'b0, 0, 2'b00, 1'b0, 0);
        run_cmd(130, 32'h0000_0FF0, 4'h1, 1'b1, 1'b0, 0, 2'b00, 1'b0, 0);
        run_cmd(200, 32'h0000_3F80, 4'h3, 1'b1, 1'b1, 0, 2'b00, 1'b0, 0);
        run_cmd(40,  32'h0000_0500, 4'h2, 1'b1, 1'b0, 3, 2'b10, 1'b0, 0);
        run_cmd(32,  32'h0000_0800, 4'h1, 1'b1, 1'b1, 5, 2'b11, 1'b0, 0);
        run_cmd(0,   32'h0000_1000, 4'h9, 1'b1, 1'b0, 0, 2'b00, 1'b0, 0);
        run_cmd(16,  32'h0000_1002, 4'h6, 1'b1, 1'b0, 0, 2'b00, 1'b0, 2);
        run_cmd(23,  32'h0000_2000, 4'h4, 1'b0, 1'b0, 0, 2'b00, 1'b0, 10);
        run_cmd(24,  32'h0000_0900, 4'hA, 1'b1, 1'b0, 0, 2'b00, 1'b1, 0);
        run_cmd(4,   32'h0000_0FFC, 4'hB, 1'b1, 1'b0, 0, 2'b00, 1'b0, 0);

        // Randomized commands, biased toward page boundaries.
        for (int k = 0; k < 10; k++) begin
            int          btt, eb;
            logic [31:0] sa;
            logic [1:0]  er;
            btt = int'($urandom_range(1, 700));
            sa  = 32'h0001_0000 + 32'($urandom_range(0, 7) << 12);
            if ($urandom_range(0, 1) == 1) sa = sa + 32'(4096 - 4 * int'($urandom_range(1, 48)));
            else                            sa = sa + 32'(4 * int'($urandom_range(0, 1000)));
            eb = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, (btt + 3) / 4)) : 0;
            er = ($urandom_range(0, 1) == 1) ? 2'b10 : 2'b11;
            run_cmd(btt, sa, 4'($urandom), 1'($urandom), 1'b1, eb, er, 1'b0,
                    int'($urandom_range(0, 3)));
        end

        // Reset in the middle of a transfer.
        pi_command    = make_cmd(256, 32'h0000_2000, 4'h7, 1'b1);
        pi_valid      = 1'b1;
        @(negedge S_AXI_ACLK);
        pi_valid      = 1'b0;
        M_AXI_ARREADY = 1'b1;
        M_AXI_RVALID  = 1'b1;
        M_AXI_RDATA   = 32'hDEAD_BEEF;
        M_AXIS_TREADY = 1'b1;
        pi_sts_tready = 1'b1;
        repeat (6) @(negedge S_AXI_ACLK);
        S_AXI_ARESETN = 1'b0;
        @(negedge S_AXI_ACLK);
        #1;
        check_reset_outputs("midrst");
        M_AXI_ARREADY = 1'b0;
        M_AXI_RVALID  = 1'b0;
        M_AXIS_TREADY = 1'b0;
        pi_sts_tready = 1'b0;
        S_AXI_ARESETN = 1'b1;
        @(negedge S_AXI_ACLK);
        #1;
        check_eq("midrst_ready_back", po_ready, 1'b1);
        check_eq("midrst_no_sts", po_sts_tvalid, 1'b0);

        // Engine works normally after the reset.
        run_cmd(48, 32'h0000_4000, 4'hC, 1'b1, 1'b0, 0, 2'b00, 1'b0, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
